// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch / load-store arbiter sharing one single-port synchronous memory
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_wstrb,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   logic [3:0]             starve_cnt;
   logic [MEM_LATENCY-1:0] tag_valid;
   logic [MEM_LATENCY-1:0] tag_owner;
   logic                   fetch_first;
   logic                   store_gnt;
   logic                   rd_accept;

   // Data normally wins a collision; a fetch denied long enough takes over.
   assign fetch_first = (starve_cnt >= 4'(STARVE_LIMIT));
   assign d_gnt       = ~areset & d_req & ~(if_req & fetch_first);
   assign if_gnt      = ~areset & if_req & ~(d_req & ~fetch_first);
   assign store_gnt   = d_gnt & d_we;
   assign rd_accept   = if_gnt | (d_gnt & ~d_we);

   assign mem_en    = if_gnt | d_gnt;
   assign mem_we    = store_gnt;
   assign mem_addr  = if_gnt ? {if_addr[ADDR_WIDTH-1:2], 2'b00} :
                      d_gnt  ? {d_addr[ADDR_WIDTH-1:2], 2'b00}  : '0;
   assign mem_wdata = store_gnt ? d_wdata : '0;
   assign mem_wstrb = store_gnt ? d_wstrb : 4'b0000;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         starve_cnt <= 4'd0;
      end else if (if_req & ~if_gnt) begin
         starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      end else begin
         starve_cnt <= 4'd0;
      end
   end

   // Stage 0 holds the newest issue; the top stage lines up with mem_rdata.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         tag_valid <= '0;
         tag_owner <= '0;
      end else begin
         tag_valid <= MEM_LATENCY'({tag_valid, rd_accept});
         tag_owner <= MEM_LATENCY'({tag_owner, d_gnt});
      end
   end

   assign if_rvalid = ~areset & tag_valid[MEM_LATENCY-1] & ~tag_owner[MEM_LATENCY-1];
   assign d_rvalid  = ~areset & tag_valid[MEM_LATENCY-1] &  tag_owner[MEM_LATENCY-1];
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
